// File: rtl/topo2a_ad_proj_mac_pipe.sv
// Topo2A projection MAC: pipelined signed x unsigned multiply, run accumulation
// terminated by in_last, optional round-half-up shift, and saturation to DOUT_WIDTH.
module topo2a_ad_proj_mac_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 25,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 40,
    parameter int SHIFT      = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIN0_WIDTH-1:0]        din0,
    input  logic [DIN1_WIDTH-1:0]        din1,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] out_data,
    output logic                         out_sat,
    output logic [7:0]                   out_nterm
);

    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
    localparam int EXT = ACC_WIDTH - PW;

    localparam logic signed [ACC_WIDTH:0] OUT_MAX_W =
        {{(ACC_WIDTH + 2 - DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN_W =
        {{(ACC_WIDTH + 2 - DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH - 1){1'b0}}};
    localparam logic signed [DOUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DOUT_WIDTH - 1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DOUT_WIDTH - 1){1'b0}}};

    // Pipeline stage storage: valid, product and last flag per register stage
    logic                 stageValid_q [NUM_STAGE];
    logic signed [PW-1:0] stageProd_q  [NUM_STAGE];
    logic                 stageLast_q  [NUM_STAGE];

    // Accumulator and output registers with their next-state values
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [7:0]                   nterm_q, nterm_d;
    logic                         outValid_q, outValid_d;
    logic signed [DOUT_WIDTH-1:0] outData_q, outData_d;
    logic                         outSat_q, outSat_d;
    logic [7:0]                   outNterm_q, outNterm_d;

    logic                         adv;
    logic signed [PW-1:0]         opA;
    logic signed [PW-1:0]         opB;
    logic signed [PW-1:0]         product;
    logic                         finalValid;
    logic                         finalLast;
    logic signed [PW-1:0]         finalProd;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH:0]    sumWide;
    logic signed [ACC_WIDTH:0]    roundVal;
    logic signed [DOUT_WIDTH-1:0] satData;
    logic                         satFlag;
    logic [7:0]                   ntermInc;

    // The whole pipeline moves only when the output slot can be vacated
    assign adv      = !(outValid_q && !out_ready);
    assign in_ready = adv && ap_rst_n;

    // Both operands are widened to the full product width so the multiply is exact;
    // din1 is zero-extended so it always acts as a non-negative magnitude
    assign opA     = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
    assign opB     = {{DIN0_WIDTH{1'b0}}, din1};
    assign product = opA * opB;

    assign finalValid = stageValid_q[NUM_STAGE-1];
    assign finalLast  = stageLast_q[NUM_STAGE-1];
    assign finalProd  = stageProd_q[NUM_STAGE-1];

    assign sum      = acc_q + {{EXT{finalProd[PW-1]}}, finalProd};
    assign sumWide  = {sum[ACC_WIDTH-1], sum};
    assign ntermInc = (nterm_q == 8'hFF) ? 8'hFF : nterm_q + 8'd1;

    // Round-half-up arithmetic shift, done one bit wider so the bias cannot overflow
    generate
        if (SHIFT == 0) begin : g_noRound
            assign roundVal = sumWide;
        end else begin : g_round
            localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
            logic signed [ACC_WIDTH:0] biased;
            assign biased   = sumWide + HALF;
            assign roundVal = biased >>> SHIFT;
        end
    endgenerate

    // Clip the rounded sum into the signed output range and flag any clipping
    always_comb begin
        satData = roundVal[DOUT_WIDTH-1:0];
        satFlag = 1'b0;
        if (roundVal > OUT_MAX_W) begin
            satData = OUT_MAX;
            satFlag = 1'b1;
        end else if (roundVal < OUT_MIN_W) begin
            satData = OUT_MIN;
            satFlag = 1'b1;
        end
    end

    // Shift products through the stage registers whenever the pipeline advances
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int k = 0; k < NUM_STAGE; k++) begin
                stageValid_q[k] <= 1'b0;
                stageProd_q[k]  <= '0;
                stageLast_q[k]  <= 1'b0;
            end
        end else if (adv) begin
            stageValid_q[0] <= in_valid;
            stageProd_q[0]  <= product;
            stageLast_q[0]  <= in_last;
            for (int k = 1; k < NUM_STAGE; k++) begin
                stageValid_q[k] <= stageValid_q[k-1];
                stageProd_q[k]  <= stageProd_q[k-1];
                stageLast_q[k]  <= stageLast_q[k-1];
            end
        end
    end

    // Accumulate final-stage beats; a last beat closes the run into the output register
    always_comb begin
        acc_d      = acc_q;
        nterm_d    = nterm_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSat_d   = outSat_q;
        outNterm_d = outNterm_q;
        if (adv && finalValid) begin
            if (finalLast) begin
                acc_d   = '0;
                nterm_d = '0;
            end else begin
                acc_d   = sum;
                nterm_d = ntermInc;
            end
        end
        if (adv && finalValid && finalLast) begin
            outValid_d = 1'b1;
            outData_d  = satData;
            outSat_d   = satFlag;
            outNterm_d = ntermInc;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // Register accumulator state and the output handshake slot
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q      <= '0;
            nterm_q    <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSat_q   <= 1'b0;
            outNterm_q <= '0;
        end else begin
            acc_q      <= acc_d;
            nterm_q    <= nterm_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSat_q   <= outSat_d;
            outNterm_q <= outNterm_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_sat   = outSat_q;
    assign out_nterm = outNterm_q;

endmodule

// File: doc/topo2a_ad_proj_mac_pipe.md
# topo2a_ad_proj_mac_pipe

Pipelined, parametrised signed×unsigned multiply-accumulate unit for the Topo2A anomaly-detection projection datapath. It replaces the single-cycle combinational signed×unsigned multiplier with a stallable valid/ready pipeline. The pipeline accumulates a variable-length run of products, terminated by `in_last`, then rounds, saturates and emits one dot-product result per run. It sits between the feature/weight streamer and the latent-layer activation stage.

## Interface
Reset is synchronous and active-low on a single clock.

Parameters:
- DIN0_WIDTH, 16, width of signed operand din0
- DIN1_WIDTH, 10, width of unsigned operand din1; always zero-extended
- DOUT_WIDTH, 25, signed result width
- NUM_STAGE, 2, multiplier pipeline registers; legal range 1..4
- ACC_WIDTH, 40, signed accumulator width; must be ≥ DIN0_WIDTH+DIN1_WIDTH+4
- SHIFT, 0, arithmetic right shift with round-half-up applied before saturation; must satisfy 0 ≤ SHIFT < ACC_WIDTH−DOUT_WIDTH

Ports:
- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- din0  in  DIN0_WIDTH  signed operand
- din1  in  DIN1_WIDTH  unsigned operand
- in_last  in  1  beat is the final term of the current run
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DOUT_WIDTH  rounded, saturated sum
- out_sat  out  1  out_data was clipped
- out_nterm  out  8  terms in the run; saturates at 255

## Operation
- Product: P = $signed(din0) × $signed({1'b0,din1}), computed exactly in DIN0_WIDTH+DIN1_WIDTH bits. No truncation.
- Pipeline: NUM_STAGE registered stages, each with a valid bit, carrying P and last.
- Global advance: adv = !(out_valid && !out_ready). All stages and the accumulator update only when adv is high.
- in_ready = adv && ap_rst_n.
- Accumulator: on a final-stage beat with adv high, sum = acc + sext(P).
  - Not last: acc ← sum and nterm ← sat255(nterm+1).
  - Last: acc ← 0 and nterm ← 0. The output register loads the finished result.
- The accumulator wraps modulo 2^ACC_WIDTH. By the width rule, wrap cannot occur below 16 terms.
- Rounding:
  - SHIFT = 0: r = sum.
  - SHIFT > 0: r = (sum + 2^(SHIFT−1)) >>> SHIFT, computed in ACC_WIDTH+1 bits.
- Saturation:
  - r > 2^(DOUT_WIDTH−1)−1: out_data = max and out_sat = 1.
  - r < −2^(DOUT_WIDTH−1): out_data = min and out_sat = 1.
  - Otherwise out_data = r and out_sat = 0.
- Output register load: out_nterm ← sat255(nterm+1) and out_valid ← 1.
- Output register clear: out_valid ← 0 when out_ready is high and no new result loads in the same edge.
- Output register simultaneous load: if out_ready is high and a new result loads in the same edge, the new result replaces the old one and out_valid stays 1.
- A single-term run (in_last=1 on every beat) gives plain pipelined multiply.
- Reset (ap_rst_n=0 at an edge):
  - All stage valid bits cleared; in-flight beats discarded.
  - acc, nterm, out_data, out_sat and out_nterm cleared to 0.
  - out_valid cleared to 0.
  - in_ready is held 0 during reset.
  - A partial run is abandoned. The next run starts from 0.

## Timing
- Throughput: one beat per cycle while out_ready stays high.
- Latency: the last beat is accepted at edge E. out_valid is high starting from edge E+NUM_STAGE.
- Back-to-back runs need no bubble: a new run's first beat may be accepted in the cycle after the previous last.
- Backpressure: while out_valid && !out_ready:
  - in_ready = 0.
  - Stage contents, acc, out_data, out_sat and out_nterm are held stable.
  - No beat is lost or duplicated.
- Output is a registered valid/ready handshake. out_data must not change while out_valid && !out_ready.
- All outputs are registered except in_ready, which is combinational from out_valid, out_ready and ap_rst_n.

## Test plan
- Single-term run, defaults: din0=−3, din1=5, last=1 → out_data=−15, out_sat=0, out_nterm=1. out_valid is high 2 edges after acceptance.
- Unsigned operand and saturation, defaults: din0=32767, din1=1023, last=1. Exact product is 33,520,641 → out_data=16,777,215, out_sat=1.
- Four-term dot product: (100,2), (−50,4), (7,10), (−1,1 last) → out_data=69, out_sat=0, out_nterm=4. A following single-term run (2,3) gives 6 with no bubble.
- Backpressure: 6 back-to-back single-term beats with din0=1..6 and din1=1. Hold out_ready=0 for 3 cycles after the first out_valid → in_ready=0 during the hold, out_data stays 1, and the outputs 1..6 arrive in order with none lost.
- Rounding, SHIFT=4 instance: din0=−24 → −1; din0=40 → 3; din0=8 → 1; all with din1=1 and last=1.
- Reset mid-run: accept (10,10) and (20,20) with no last, pull ap_rst_n low for 1 cycle, then send (3,3,last) → out_data=9 and out_nterm=1. No out_valid appears for the abandoned terms.
